// File: rtl/keypad_lcd_writer_if.sv
// Handshake bundle between the keypad LCD writer and the I2C master.
// master: the writer (drives address/data/request), slave: the I2C master (drives busy).
interface keypad_lcd_writer_if;
   logic [6:0] o_addr;
   logic [7:0] o_data;
   logic       o_RW;
   logic       o_valid;
   logic       i_busy;

   modport master (output o_addr, output o_data, output o_RW, output o_valid, input i_busy);
   modport slave  (input o_addr, input o_data, input o_RW, input o_valid, output i_busy);
endinterface

// File: rtl/keypad_lcd_writer.sv
// keypad_lcd_writer: turns keypad codes into HD44780 4-bit-mode writes through a
// PCF8574-style I2C backpack. Each byte becomes four nibble transactions
// (high EN=1, high EN=0, low EN=1, low EN=0). Tracks the cursor internally,
// re-addresses DDRAM on row wrap, and handles a clear-screen request.
// Optional key queue enabled by defining KEYPAD_FIFO_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for a clear (priority) or a key
// LOAD      | present nibble r_step of r_byte and raise the request
// REQ       | o_valid held until the I2C master's busy rises
// WAIT_FALL | waiting for busy to fall (transaction complete)
// SETTLE    | down-count settle time (longer after the last clear nibble)
// NEXT      | advance nibble step, chain a DDRAM address after a wrap, or finish
module keypad_lcd_writer #(
   parameter logic [6:0] I2C_ADDR      = 7'h27,
   parameter int         COLS          = 16,
   parameter int         ROWS          = 2,
   parameter int         SETTLE_CYCLES = 100000,
   parameter int         CLEAR_CYCLES  = 200000,
   parameter int         FIFO_DEPTH    = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [3:0]                 i_data,
   input  logic                       i_btn_valid,
   input  logic                       i_clear,
   keypad_lcd_writer_if.master        i2c_bus,
   output logic [1:0]                 o_row,
   output logic [5:0]                 o_col,
   output logic                       o_idle,
   output logic                       o_dropped
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT_FALL, S_SETTLE, S_NEXT} state_t;
   typedef enum logic [1:0] {K_CHAR, K_CLEAR, K_GOTO} kind_t;

   localparam logic [31:0] SET_LD = 32'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [31:0] CLR_LD = 32'((CLEAR_CYCLES  > 0) ? CLEAR_CYCLES  - 1 : 0);
   localparam int          CW     = $clog2(FIFO_DEPTH + 1);

   state_t      r_state;
   kind_t       r_kind;
   logic [7:0]  r_byte;
   logic [1:0]  r_step;
   logic [7:0]  r_data;
   logic        r_valid;
   logic        r_busy_d;
   logic [31:0] r_cnt;
   logic [1:0]  r_row;
   logic [5:0]  r_col;
   logic        r_clear_pend;
   logic        r_dropped;

   logic        w_busy_rise;
   logic        w_busy_fall;
   logic        w_in_idle;
   logic        w_clear_now;
   logic        w_key_go;
   logic [3:0]  w_key_code;
   logic        w_drop;
   logic        w_fifo_empty;
   logic [7:0]  w_key_ascii;

   function automatic logic [7:0] f_key2ascii(input logic [3:0] k);
      return (k < 4'd10) ? (8'h30 + {4'h0, k}) : (8'h37 + {4'h0, k});
   endfunction

   // {D7..D4, BL, EN, RW, RS}; steps 0/1 carry the high nibble, EN high on even steps
   function automatic logic [7:0] f_nibble(input logic [7:0] b, input logic [1:0] step,
                                           input logic rs);
      logic [3:0] nib;
      nib = step[1] ? b[3:0] : b[7:4];
      return {nib, 1'b1, ~step[0], 1'b0, rs};
   endfunction

   function automatic logic [7:0] f_goto(input logic [1:0] row);
      case (row)
         2'd0:    return 8'h80;
         2'd1:    return 8'hC0;
         2'd2:    return 8'h94;
         default: return 8'hD4;
      endcase
   endfunction

   assign w_busy_rise = i2c_bus.i_busy & ~r_busy_d;
   assign w_busy_fall = ~i2c_bus.i_busy & r_busy_d;
   assign w_in_idle   = (r_state == S_IDLE);
   assign w_clear_now = w_in_idle & (i_clear | r_clear_pend);
   assign w_key_ascii = f_key2ascii(w_key_code);

`ifdef KEYPAD_FIFO_EN
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [3:0]    r_fifo [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_fifo_full;
   logic          w_bypass;
   logic          w_pop;
   logic          w_push_req;
   logic          w_push;

   // An empty queue in IDLE lets a fresh key skip the queue to keep N+1 latency
   assign w_fifo_empty = (r_count == '0);
   assign w_fifo_full  = (r_count == CW'(FIFO_DEPTH));
   assign w_bypass     = w_in_idle & ~w_clear_now & w_fifo_empty & i_btn_valid;
   assign w_pop        = w_in_idle & ~w_clear_now & ~w_fifo_empty;
   assign w_push_req   = i_btn_valid & ~w_bypass;
   assign w_push       = w_push_req & (~w_fifo_full | w_pop);
   assign w_drop       = w_push_req & w_fifo_full & ~w_pop;
   assign w_key_go     = w_bypass | w_pop;
   assign w_key_code   = w_pop ? r_fifo[r_rd_ptr] : i_data;

   // Queue storage; no reset needed, occupancy is tracked by r_count
   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr] <= i_data;
   end

   // Queue pointers and occupancy
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= (r_wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= (r_rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end
`else
   logic [CW-1:0] w_count;

   // Without a queue keys are taken only in IDLE and lose to a clear
   assign w_count      = '0;
   assign w_fifo_empty = (w_count == '0);
   assign w_key_go     = w_in_idle & ~w_clear_now & i_btn_valid;
   assign w_key_code   = i_data;
   assign w_drop       = i_btn_valid & ~w_key_go;
`endif

   // Main sequencer: byte selection, nibble handshake, settle timing, cursor tracking
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_kind       <= K_CHAR;
         r_byte       <= '0;
         r_step       <= '0;
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_busy_d     <= 1'b0;
         r_cnt        <= '0;
         r_row        <= '0;
         r_col        <= '0;
         r_clear_pend <= 1'b0;
         r_dropped    <= 1'b0;
      end else begin
         r_busy_d  <= i2c_bus.i_busy;
         r_dropped <= w_drop;
         if (i_clear && !w_in_idle) r_clear_pend <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (w_clear_now) begin
                  r_clear_pend <= 1'b0;
                  r_kind       <= K_CLEAR;
                  r_byte       <= 8'h01;
                  r_step       <= 2'd0;
                  r_data       <= f_nibble(8'h01, 2'd0, 1'b0);
                  r_valid      <= 1'b1;
                  r_state      <= S_REQ;
               end else if (w_key_go) begin
                  r_kind  <= K_CHAR;
                  r_byte  <= w_key_ascii;
                  r_step  <= 2'd0;
                  r_data  <= f_nibble(w_key_ascii, 2'd0, 1'b1);
                  r_valid <= 1'b1;
                  r_state <= S_REQ;
               end
            end
            S_LOAD: begin
               r_data  <= f_nibble(r_byte, r_step, r_kind == K_CHAR);
               r_valid <= 1'b1;
               r_state <= S_REQ;
            end
            S_REQ: begin
               if (w_busy_rise) begin
                  r_valid <= 1'b0;
                  r_state <= S_WAIT_FALL;
               end
            end
            S_WAIT_FALL: begin
               if (w_busy_fall) begin
                  r_cnt   <= (r_kind == K_CLEAR && r_step == 2'd3) ? CLR_LD : SET_LD;
                  r_state <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (r_cnt == '0) begin
                  r_state <= S_NEXT;
                  if (r_step == 2'd3) begin
                     if (r_kind == K_CHAR) begin
                        if (r_col == 6'(COLS - 1)) begin
                           r_col <= '0;
                           r_row <= (r_row == 2'(ROWS - 1)) ? 2'd0 : r_row + 2'd1;
                        end else begin
                           r_col <= r_col + 6'd1;
                        end
                     end else if (r_kind == K_CLEAR) begin
                        r_col <= '0;
                        r_row <= '0;
                     end
                  end
               end else begin
                  r_cnt <= r_cnt - 32'd1;
               end
            end
            S_NEXT: begin
               if (r_step != 2'd3) begin
                  r_step  <= r_step + 2'd1;
                  r_state <= S_LOAD;
               end else if (r_kind == K_CHAR && r_col == '0) begin
                  // column wrapped on this character: re-address the new row
                  r_kind  <= K_GOTO;
                  r_byte  <= f_goto(r_row);
                  r_step  <= 2'd0;
                  r_state <= S_LOAD;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign i2c_bus.o_addr  = I2C_ADDR;
   assign i2c_bus.o_RW    = 1'b0;
   assign i2c_bus.o_data  = r_data;
   assign i2c_bus.o_valid = r_valid;
   assign o_row           = r_row;
   assign o_col           = r_col;
   assign o_dropped       = r_dropped;
   assign o_idle          = w_in_idle & ~r_clear_pend & w_fifo_empty;

endmodule

// File: tb/tb_keypad_lcd_writer.sv
// Directed bench for keypad_lcd_writer with short settle times.
`timescale 1ns/1ps
module tb_keypad_lcd_writer;
   localparam int COLS = 16;
   localparam int ROWS = 2;
   localparam int SET  = 3;
   localparam int CLR  = 7;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] i_data = '0;
   logic       i_btn_valid = 1'b0;
   logic       i_clear = 1'b0;
   logic [1:0] o_row;
   logic [5:0] o_col;
   logic       o_idle;
   logic       o_dropped;

   int checks = 0;
   int errors = 0;

   keypad_lcd_writer_if bus();

   keypad_lcd_writer #(
      .I2C_ADDR(7'h27), .COLS(COLS), .ROWS(ROWS),
      .SETTLE_CYCLES(SET), .CLEAR_CYCLES(CLR), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_btn_valid(i_btn_valid),
      .i_clear(i_clear), .i2c_bus(bus), .o_row(o_row), .o_col(o_col),
      .o_idle(o_idle), .o_dropped(o_dropped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // I2C master model: wait for a request, check it, run a busy pulse
   task automatic xact(input logic [7:0] exp, input string tag);
      int n = 0;
      while (bus.o_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " valid"}, {31'd0, bus.o_valid}, 32'd1);
      chk(tag, {24'd0, bus.o_data}, {24'd0, exp});
      bus.i_busy = 1'b1;
      repeat (3) @(negedge clk);
      chk({tag, " valid low"}, {31'd0, bus.o_valid}, 32'd0);
      bus.i_busy = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic rs, input string tag);
      xact({b[7:4], 1'b1, 1'b1, 1'b0, rs}, {tag, " n0"});
      xact({b[7:4], 1'b1, 1'b0, 1'b0, rs}, {tag, " n1"});
      xact({b[3:0], 1'b1, 1'b1, 1'b0, rs}, {tag, " n2"});
      xact({b[3:0], 1'b1, 1'b0, 1'b0, rs}, {tag, " n3"});
   endtask

   task automatic wait_idle(input int exp, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (o_idle !== 1'b1 && n < 1000);
      chk(tag, n, exp);
   endtask

   task automatic press_key(input logic [3:0] k, input string tag);
      i_data = k;
      i_btn_valid = 1'b1;
      @(negedge clk);
      i_btn_valid = 1'b0;
      chk({tag, " N+1 valid"}, {31'd0, bus.o_valid}, 32'd1);
   endtask

   task automatic press_clear(input string tag);
      i_clear = 1'b1;
      @(negedge clk);
      i_clear = 1'b0;
      chk({tag, " N+1 valid"}, {31'd0, bus.o_valid}, 32'd1);
   endtask

   initial begin
      bus.i_busy = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst valid", {31'd0, bus.o_valid}, 32'd0);
      chk("rst data", {24'd0, bus.o_data}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst row", {30'd0, o_row}, 32'd0);
      chk("rst col", {26'd0, o_col}, 32'd0);
      chk("rst idle", {31'd0, o_idle}, 32'd1);
      chk("rst dropped", {31'd0, o_dropped}, 32'd0);
      chk("addr", {25'd0, bus.o_addr}, 32'h27);
      chk("rw", {31'd0, bus.o_RW}, 32'd0);

      // key A at (0,0)
      press_key(4'hA, "keyA");
      xact(8'h4D, "keyA n0");
      xact(8'h49, "keyA n1");
      xact(8'h1D, "keyA n2");
      xact(8'h19, "keyA n3");
      wait_idle(SET + 2, "keyA settle");
      chk("keyA col", {26'd0, o_col}, 32'd1);
      chk("keyA idle", {31'd0, o_idle}, 32'd1);

      // clear and key in the same cycle
      i_clear = 1'b1;
      i_btn_valid = 1'b1;
      i_data = 4'h5;
      @(negedge clk);
      i_clear = 1'b0;
      i_btn_valid = 1'b0;
      chk("clr+key valid", {31'd0, bus.o_valid}, 32'd1);
      chk("clr+key data", {24'd0, bus.o_data}, 32'h0C);
`ifdef KEYPAD_FIFO_EN
      chk("clr+key dropped", {31'd0, o_dropped}, 32'd0);
`else
      chk("clr+key dropped", {31'd0, o_dropped}, 32'd1);
`endif
      xact(8'h0C, "clr n0");
      xact(8'h08, "clr n1");
      xact(8'h1C, "clr n2");
      xact(8'h18, "clr n3");
`ifdef KEYPAD_FIFO_EN
      send_byte(8'h35, 1'b1, "queued key5");
      wait_idle(SET + 2, "queued key5 settle");
      chk("queued key5 col", {26'd0, o_col}, 32'd1);
      press_clear("clr2");
      send_byte(8'h01, 1'b0, "clr2");
      wait_idle(CLR + 2, "clr2 settle");
`else
      wait_idle(CLR + 2, "clr settle");
`endif
      chk("clr row", {30'd0, o_row}, 32'd0);
      chk("clr col", {26'd0, o_col}, 32'd0);

      // 16 characters on row 0, wrap to row 1
      for (int i = 0; i < 16; i++) begin
         press_key(4'h0, $sformatf("wrap0 k%0d", i));
         xact(8'h3D, "wrap0 n0");
         xact(8'h39, "wrap0 n1");
         xact(8'h0D, "wrap0 n2");
         xact(8'h09, "wrap0 n3");
         if (i < 15) begin
            wait_idle(SET + 2, "wrap0 settle");
            chk($sformatf("wrap0 col k%0d", i), {26'd0, o_col}, i + 1);
         end
      end
      xact(8'hCC, "goto row1 n0");
      xact(8'hC8, "goto row1 n1");
      xact(8'h0C, "goto row1 n2");
      xact(8'h08, "goto row1 n3");
      wait_idle(SET + 2, "goto row1 settle");
      chk("wrap0 row", {30'd0, o_row}, 32'd1);
      chk("wrap0 col", {26'd0, o_col}, 32'd0);

      // 16 characters on row 1, wrap back to row 0
      for (int i = 0; i < 16; i++) begin
         press_key(4'hF, $sformatf("wrap1 k%0d", i));
         xact(8'h4D, "wrap1 n0");
         xact(8'h49, "wrap1 n1");
         xact(8'h6D, "wrap1 n2");
         xact(8'h69, "wrap1 n3");
         if (i < 15) begin
            wait_idle(SET + 2, "wrap1 settle");
            chk($sformatf("wrap1 row k%0d", i), {30'd0, o_row}, 32'd1);
         end
      end
      xact(8'h8C, "goto row0 n0");
      xact(8'h88, "goto row0 n1");
      xact(8'h0C, "goto row0 n2");
      xact(8'h08, "goto row0 n3");
      wait_idle(SET + 2, "goto row0 settle");
      chk("wrap1 row", {30'd0, o_row}, 32'd0);
      chk("wrap1 col", {26'd0, o_col}, 32'd0);

`ifdef KEYPAD_FIFO_EN
      // five keys pushed while the first is in flight: four queue, one drops
      press_key(4'h1, "fifo k1");
      i_btn_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         i_data = 4'(2 + i);
         @(negedge clk);
         chk($sformatf("fifo drop %0d", i), {31'd0, o_dropped}, (i == 4) ? 32'd1 : 32'd0);
      end
      i_btn_valid = 1'b0;
      send_byte(8'h31, 1'b1, "fifo c1");
      send_byte(8'h32, 1'b1, "fifo c2");
      send_byte(8'h33, 1'b1, "fifo c3");
      send_byte(8'h34, 1'b1, "fifo c4");
      send_byte(8'h35, 1'b1, "fifo c5");
      wait_idle(SET + 2, "fifo settle");
      chk("fifo col", {26'd0, o_col}, 32'd5);
      press_clear("clr3");
      send_byte(8'h01, 1'b0, "clr3");
      wait_idle(CLR + 2, "clr3 settle");
`else
      // key while busy drops; clear while busy is latched and runs next
      press_key(4'h1, "busy k1");
      i_data = 4'h7;
      i_btn_valid = 1'b1;
      @(negedge clk);
      i_btn_valid = 1'b0;
      chk("busy key dropped", {31'd0, o_dropped}, 32'd1);
      chk("busy valid held", {31'd0, bus.o_valid}, 32'd1);
      i_clear = 1'b1;
      @(negedge clk);
      i_clear = 1'b0;
      chk("dropped one-shot", {31'd0, o_dropped}, 32'd0);
      send_byte(8'h31, 1'b1, "busy c1");
      send_byte(8'h01, 1'b0, "latched clr");
      wait_idle(CLR + 2, "latched clr settle");
`endif
      chk("after clr row", {30'd0, o_row}, 32'd0);
      chk("after clr col", {26'd0, o_col}, 32'd0);

      // reset while waiting for busy to fall
      press_key(4'h3, "rst pre");
      send_byte(8'h33, 1'b1, "rst pre");
      wait_idle(SET + 2, "rst pre settle");
      chk("rst pre col", {26'd0, o_col}, 32'd1);
      press_key(4'h2, "rst k2");
      bus.i_busy = 1'b1;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midrst valid", {31'd0, bus.o_valid}, 32'd0);
      chk("midrst data", {24'd0, bus.o_data}, 32'd0);
      chk("midrst col", {26'd0, o_col}, 32'd0);
      chk("midrst idle", {31'd0, o_idle}, 32'd1);
      bus.i_busy = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("postrst idle", {31'd0, o_idle}, 32'd1);
      chk("postrst row", {30'd0, o_row}, 32'd0);
      chk("postrst col", {26'd0, o_col}, 32'd0);
      press_key(4'h4, "postrst k4");
      chk("postrst data", {24'd0, bus.o_data}, 32'h3D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
